// File: rtl/pgm_loader_pkg.sv
// pgm_loader_pkg: loader FSM states and beat-geometry helpers shared by the DDRAM loader.
package pgm_loader_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
   localparam int unsigned IOCTL_AW = 27;
   function automatic int lanes(input int ddr_dw, input int ioctl_dw);
      return ddr_dw / ioctl_dw;
   endfunction
endpackage

// File: rtl/pgm_beat_fifo.sv
// pgm_beat_fifo: synchronous circular FIFO of packed beats with an occupancy count.
module pgm_beat_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic [CW-1:0] count_o
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PW'(1);
         if (pop_i) rd_q <= rd_q + PW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end
   assign dout_o  = mem_q[rd_q];
   assign count_o = count_q;
endmodule

// File: rtl/pgm_ddram_loader.sv
// pgm_ddram_loader: packs ioctl download words into per-region DDRAM beats behind a small FIFO.
// Define PGM_LOADER_CHECKSUM_EN to build the running download checksum.
module pgm_ddram_loader
   import pgm_loader_pkg::*;
#(
   parameter int                            IOCTL_DW    = 16,
   parameter int                            DDR_DW      = 64,
   parameter int                            DDR_AW      = 29,
   parameter int                            NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*DDR_AW-1:0] REGION_BASE = '0,
   parameter int                            FIFO_DEPTH  = 4
) (
   input  logic                fixed_50m_clk,
   input  logic                reset,
   input  logic                ioctl_download,
   input  logic                ioctl_wr,
   input  logic [IOCTL_AW-1:0] ioctl_addr,
   input  logic [IOCTL_DW-1:0] ioctl_dout,
   input  logic [7:0]          ioctl_index,
   output logic                ioctl_wait,
   output logic [DDR_AW-1:0]   ddram_addr,
   output logic [DDR_DW-1:0]   ddram_din,
   output logic [DDR_DW/8-1:0] ddram_be,
   output logic                ddram_we,
   input  logic                ddram_busy,
   output logic                load_done,
   output logic [31:0]         load_checksum
);
   localparam int BE_W = DDR_DW / 8;
   localparam int WBE  = IOCTL_DW / 8;
   localparam int BB   = $clog2(BE_W);
   localparam int WB   = $clog2(WBE);
   localparam int LW   = $clog2(lanes(DDR_DW, IOCTL_DW));
   localparam int CW   = $clog2(FIFO_DEPTH) + 1;
   typedef struct packed {
      logic [DDR_AW-1:0] addr;
      logic [DDR_DW-1:0] data;
      logic [BE_W-1:0]   be;
   } beat_t;
   state_t            state_q, state_d;
   beat_t             acc_q, acc_d, head;
   logic [CW-1:0]     count;
   logic [DDR_AW-1:0] base, waddr;
   logic [LW-1:0]     lane;
   logic              wr_ok, flush, pop, drained;
   always_comb begin
      base = '0;
      for (int r = 0; r < NUM_REGIONS; r++)
         if (ioctl_index == 8'(r)) base = REGION_BASE[r*DDR_AW +: DDR_AW];
   end
   assign waddr = base + DDR_AW'(ioctl_addr >> BB);
   assign lane  = LW'(ioctl_addr[BB-1:0] >> WB);
   assign wr_ok = ioctl_wr & ioctl_download & (ioctl_index < 8'(NUM_REGIONS)) & (state_q != DRAIN);
   // An open beat leaves when its top lane fills, a write moves to another beat, or the download ends.
   assign flush = |acc_q.be & (acc_q.be[BE_W-1] | ~ioctl_download | (wr_ok & (waddr != acc_q.addr)));
   always_comb begin
      acc_d = flush ? '0 : acc_q;
      if (wr_ok) begin
         acc_d.addr                            = waddr;
         acc_d.data[lane*IOCTL_DW +: IOCTL_DW] = ioctl_dout;
         acc_d.be[lane*WBE +: WBE]             = '1;
      end
   end
   assign ddram_we   = |count;
   assign pop        = ddram_we & ~ddram_busy;
   assign ddram_addr = ddram_we ? head.addr : '0;
   assign ddram_din  = ddram_we ? head.data : '0;
   assign ddram_be   = ddram_we ? head.be : '0;
   assign drained    = (count == '0) | ((count == CW'(1)) & pop);
   always_comb begin
      state_d = state_q == IDLE ? (ioctl_download ? LOAD : IDLE)
              : state_q == LOAD ? (ioctl_download ? LOAD : DRAIN)
              : (drained ? IDLE : DRAIN);
      load_done  = (state_q == DRAIN) & drained;
      ioctl_wait = (count >= CW'(FIFO_DEPTH - 1)) | ((state_q == DRAIN) & ioctl_download);
   end
   always_ff @(posedge fixed_50m_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end
   pgm_beat_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i  (fixed_50m_clk),
      .rst_i  (reset),
      .push_i (flush),
      .din_i  (acc_q),
      .pop_i  (pop),
      .dout_o (head),
      .count_o(count)
   );
`ifdef PGM_LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
   always_comb begin
      sum_d = ((state_q == IDLE) & ioctl_download) ? '0 : sum_q;
      if (wr_ok) sum_d = sum_d + 32'(ioctl_dout);
   end
   always_ff @(posedge fixed_50m_clk or posedge reset) begin
      if (reset) sum_q <= '0;
      else sum_q <= sum_d;
   end
   assign load_checksum = sum_q;
`else
   assign load_checksum = '0;
`endif
endmodule

// File: tb/tb_pgm_ddram_loader.sv
// tb_pgm_ddram_loader: directed vector table plus multi-cycle sequences for the DDRAM loader.
module tb_pgm_ddram_loader;
`ifdef PGM_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   localparam logic [4*29-1:0] BASES = {29'h0000200, 29'h0100000, 29'h1FFFFFFF, 29'h0000000};

   logic        clk = 1'b0, reset = 1'b1;
   logic        ioctl_download = 1'b0, ioctl_wr = 1'b0, ddram_busy = 1'b0;
   logic [26:0] ioctl_addr = '0;
   logic [15:0] ioctl_dout = '0;
   logic [7:0]  ioctl_index = '0;
   logic        ioctl_wait, ddram_we, load_done;
   logic [28:0] ddram_addr;
   logic [63:0] ddram_din;
   logic [7:0]  ddram_be;
   logic [31:0] load_checksum;

   typedef struct packed { logic [28:0] a; logic [63:0] d; logic [7:0] b; } obs_t;
   typedef struct {
      logic [7:0]  idx;
      logic [26:0] addr;
      logic [15:0] dout;
      int          n;
      logic [28:0] eaddr;
      logic [7:0]  ebe;
      logic [63:0] edin;
      logic [31:0] eck;
   } vec_t;

   obs_t         got_q [$];
   vec_t         tv [7];
   int           n_cmp = 0, n_fail = 0, n_wr = 0, wr_at_wait = -1, sz_rel = 0;
   bit           wait_seen = 1'b0, hold_chk = 1'b0, stall_prev = 1'b0, ok;
   logic [127:0] held = '0;
   logic [63:0]  exp_d;

   pgm_ddram_loader #(.REGION_BASE(BASES)) dut (
      .fixed_50m_clk (clk),
      .reset         (reset),
      .ioctl_download(ioctl_download),
      .ioctl_wr      (ioctl_wr),
      .ioctl_addr    (ioctl_addr),
      .ioctl_dout    (ioctl_dout),
      .ioctl_index   (ioctl_index),
      .ioctl_wait    (ioctl_wait),
      .ddram_addr    (ddram_addr),
      .ddram_din     (ddram_din),
      .ddram_be      (ddram_be),
      .ddram_we      (ddram_we),
      .ddram_busy    (ddram_busy),
      .load_done     (load_done),
      .load_checksum (load_checksum)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_beat(input string nm, input int k, input logic [28:0] a, input logic [7:0] b, input logic [63:0] d);
      if (got_q.size() <= k) chk({nm, "_present"}, 128'(got_q.size()), 128'(k + 1));
      else begin
         chk({nm, "_addr"}, 128'(got_q[k].a), 128'(a));
         chk({nm, "_be"}, 128'(got_q[k].b), 128'(b));
         chk({nm, "_din"}, 128'(got_q[k].d), 128'(d));
      end
   endtask

   // Observe DDRAM acceptances, wait behaviour and hold-while-busy stability.
   always @(negedge clk) begin
      if (!reset) begin
         if (ddram_we && !ddram_busy) got_q.push_back({ddram_addr, ddram_din, ddram_be});
         if (ioctl_wait && !wait_seen) begin
            wait_seen  = 1'b1;
            wr_at_wait = n_wr;
         end
         if (hold_chk && stall_prev) chk("busy_hold", {26'd0, ddram_we, ddram_addr, ddram_din, ddram_be}, held);
         stall_prev = ddram_we && ddram_busy;
         held       = {26'd0, ddram_we, ddram_addr, ddram_din, ddram_be};
      end
   end

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(posedge clk) #1;
   endtask

   task automatic wr_word(input logic [26:0] a, input logic [15:0] d);
      for (int k = 0; k < 200 && ioctl_wait; k++) @(posedge clk) #1;
      if (ioctl_wait) chk("wait_bound", 128'(ioctl_wait), 128'(0));
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      n_wr++;
      @(posedge clk) #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic end_dl(output bit done);
      ioctl_download = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (load_done) done = 1'b1;
      end
      @(posedge clk) #1;
   endtask

   function automatic logic [31:0] ck(input logic [15:0] v);
      return CK ? 32'(v) : 32'd0;
   endfunction

   initial begin
      tv[0] = '{8'd0, 27'h0000000, 16'hA5A5, 1, 29'h0000000, 8'h03, 64'h0000_0000_0000_A5A5, ck(16'hA5A5)};
      tv[1] = '{8'd0, 27'h000000A, 16'h1234, 1, 29'h0000001, 8'h0C, 64'h0000_0000_1234_0000, ck(16'h1234)};
      tv[2] = '{8'd2, 27'h000000C, 16'hBEEF, 1, 29'h0100001, 8'h30, 64'h0000_BEEF_0000_0000, ck(16'hBEEF)};
      tv[3] = '{8'd3, 27'h7FFFFFE, 16'hCAFE, 1, 29'h10001FF, 8'hC0, 64'hCAFE_0000_0000_0000, ck(16'hCAFE)};
      tv[4] = '{8'd1, 27'h0000008, 16'h0F0F, 1, 29'h0000000, 8'h03, 64'h0000_0000_0000_0F0F, ck(16'h0F0F)};
      tv[5] = '{8'd7, 27'h0000000, 16'h5555, 0, 29'h0000000, 8'h00, 64'h0, 32'd0};
      tv[6] = '{8'd1, 27'h0000000, 16'h7777, 1, 29'h1FFFFFFF, 8'h03, 64'h0000_0000_0000_7777, ck(16'h7777)};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we", 128'(ddram_we), 128'(0));
      chk("rst_addr", 128'(ddram_addr), 128'(0));
      chk("rst_din", 128'(ddram_din), 128'(0));
      chk("rst_be", 128'(ddram_be), 128'(0));
      chk("rst_wait", 128'(ioctl_wait), 128'(0));
      chk("rst_done", 128'(load_done), 128'(0));
      chk("rst_checksum", 128'(load_checksum), 128'(0));
      @(posedge clk) #1;
      reset = 1'b0;
      @(posedge clk) #1;

      for (int i = 0; i < 7; i++) begin
         got_q.delete();
         start_dl(tv[i].idx);
         wr_word(tv[i].addr, tv[i].dout);
         end_dl(ok);
         repeat (3) @(posedge clk) #1;
         chk($sformatf("tbl%0d_nbeats", i), 128'(got_q.size()), 128'(tv[i].n));
         if (tv[i].n == 1) begin
            chk_beat($sformatf("tbl%0d", i), 0, tv[i].eaddr, tv[i].ebe, tv[i].edin);
            chk($sformatf("tbl%0d_done", i), 128'(ok), 128'(1));
         end
         chk($sformatf("tbl%0d_checksum", i), 128'(load_checksum), 128'(tv[i].eck));
      end

      got_q.delete();
      start_dl(8'd0);
      for (int i = 0; i < 4; i++) wr_word(27'(2 * i), 16'h1111 * 16'(i + 1));
      end_dl(ok);
      repeat (2) @(posedge clk) #1;
      chk("full_nbeats", 128'(got_q.size()), 128'(1));
      chk_beat("full", 0, 29'h0, 8'hFF, 64'h4444_3333_2222_1111);
      chk("full_done", 128'(ok), 128'(1));

      got_q.delete();
      start_dl(8'd2);
      for (int i = 0; i < 3; i++) wr_word(27'(8 + 2 * i), 16'h1111 * 16'(i + 1));
      end_dl(ok);
      repeat (2) @(posedge clk) #1;
      chk("part_nbeats", 128'(got_q.size()), 128'(1));
      chk_beat("part", 0, 29'h0100001, 8'h3F, 64'h0000_3333_2222_1111);
      chk("part_done", 128'(ok), 128'(1));

      got_q.delete();
      ddram_busy = 1'b1;
      wait_seen  = 1'b0;
      wr_at_wait = -1;
      n_wr       = 0;
      hold_chk   = 1'b1;
      start_dl(8'd0);
      fork
         begin
            repeat (50) @(posedge clk);
            #1;
            sz_rel     = got_q.size();
            ddram_busy = 1'b0;
         end
         for (int i = 0; i < 24; i++) wr_word(27'(2 * i), 16'h1000 + 16'(i));
      join
      end_dl(ok);
      repeat (3) @(posedge clk) #1;
      hold_chk = 1'b0;
      chk("stall_no_early_beats", 128'(sz_rel), 128'(0));
      chk("stall_wait_seen", 128'(wait_seen), 128'(1));
      chk("stall_wait_rise_words", 128'(wr_at_wait), 128'(13));
      chk("stall_nbeats", 128'(got_q.size()), 128'(6));
      for (int b = 0; b < 6; b++) begin
         for (int l = 0; l < 4; l++) exp_d[l*16 +: 16] = 16'h1000 + 16'(4 * b + l);
         chk_beat($sformatf("stall%0d", b), b, 29'(b), 8'hFF, exp_d);
      end
      chk("stall_done", 128'(ok), 128'(1));

      got_q.delete();
      start_dl(8'd0);
      wr_word(27'h000, 16'hAAAA);
      wr_word(27'h040, 16'hBBBB);
      end_dl(ok);
      repeat (2) @(posedge clk) #1;
      chk("gap_nbeats", 128'(got_q.size()), 128'(2));
      chk_beat("gap0", 0, 29'h0, 8'h03, 64'hAAAA);
      chk_beat("gap1", 1, 29'h8, 8'h03, 64'hBBBB);

      got_q.delete();
      wait_seen = 1'b0;
      start_dl(8'd7);
      for (int i = 0; i < 8; i++) wr_word(27'(2 * i), 16'h9000 + 16'(i));
      end_dl(ok);
      repeat (4) @(posedge clk) #1;
      chk("badidx_nbeats", 128'(got_q.size()), 128'(0));
      chk("badidx_wait", 128'(wait_seen), 128'(0));

      ddram_busy = 1'b1;
      start_dl(8'd0);
      for (int i = 0; i < 8; i++) wr_word(27'(2 * i), 16'h5000 + 16'(i));
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("prerst_we", 128'(ddram_we), 128'(1));
      reset = 1'b1;
      #1;
      chk("midrst_we", 128'(ddram_we), 128'(0));
      chk("midrst_be", 128'(ddram_be), 128'(0));
      chk("midrst_wait", 128'(ioctl_wait), 128'(0));
      ioctl_download = 1'b0;
      ddram_busy     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      got_q.delete();
      @(posedge clk) #1;
      start_dl(8'd0);
      wr_word(27'h0, 16'hFFFF);
      wr_word(27'h2, 16'hFFFF);
      end_dl(ok);
      repeat (3) @(posedge clk) #1;
      chk("postrst_nbeats", 128'(got_q.size()), 128'(1));
      chk_beat("postrst", 0, 29'h0, 8'h0F, 64'h0000_0000_FFFF_FFFF);
      chk("postrst_checksum", 128'(load_checksum), 128'(CK ? 32'h0001_FFFE : 32'd0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
